// File: rtl/mem_access_unit_if.sv
// Request/response handshake and word-port memory bus for mem_access_unit.
// The slave modport is the unit; the master modport is the CPU/memory side.
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_write_data;
    logic [31:0] mem_out;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  resp_ready, mem_out,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_address, mem_read, mem_write, mem_write_data
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output resp_ready, mem_out,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_address, mem_read, mem_write, mem_write_data
    );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store initiator for a big-endian word-only memory; sub-word
// stores use read-modify-write. Latency load/word store 2, sub-word store 3, error 1.
module mem_access_unit #(
    parameter int MEM_BYTES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_access_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state, state_nxt;
    logic        we_q, sgn_q, err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, word_q, rdata_q;
    logic        accept, req_err;
    logic [31:0] aligned_in;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_val, merged;

    assign accept     = bus.req_valid && bus.req_ready;
    assign aligned_in = {bus.req_addr[31:2], 2'b00};

    always_comb begin
        req_err = 1'b0;
        if (bus.req_size == 2'b11)                                   req_err = 1'b1;
        if (bus.req_size == 2'b01 && bus.req_addr[0])                req_err = 1'b1;
        if (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)     req_err = 1'b1;
        if (aligned_in > 32'(MEM_BYTES - 4))                         req_err = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) begin
                if (req_err)                                        state_nxt = RESP;
                else if (bus.req_we && bus.req_size == 2'b10)       state_nxt = WRITE;
                else                                                state_nxt = READ;
            end
            READ:    state_nxt = we_q ? WRITE : RESP;
            WRITE:   state_nxt = RESP;
            RESP:    if (bus.resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Big-endian lanes: byte offset 0 is the most significant byte of the word.
    always_comb begin
        byte_lane = 8'h00;
        case (addr_q[1:0])
            2'd0: byte_lane = bus.mem_out[31:24];
            2'd1: byte_lane = bus.mem_out[23:16];
            2'd2: byte_lane = bus.mem_out[15:8];
            2'd3: byte_lane = bus.mem_out[7:0];
            default: byte_lane = 8'h00;
        endcase
        half_lane = addr_q[1] ? bus.mem_out[15:0] : bus.mem_out[31:16];
        case (size_q)
            2'b00:   load_val = {{24{sgn_q & byte_lane[7]}}, byte_lane};
            2'b01:   load_val = {{16{sgn_q & half_lane[15]}}, half_lane};
            default: load_val = bus.mem_out;
        endcase
    end

    always_comb begin
        merged = word_q;
        case (size_q)
            2'b00: case (addr_q[1:0])
                2'd0: merged[31:24] = wdata_q[7:0];
                2'd1: merged[23:16] = wdata_q[7:0];
                2'd2: merged[15:8]  = wdata_q[7:0];
                2'd3: merged[7:0]   = wdata_q[7:0];
                default: merged = word_q;
            endcase
            2'b01: begin
                if (addr_q[1]) merged[15:0]  = wdata_q[15:0];
                else           merged[31:16] = wdata_q[15:0];
            end
            default: merged = wdata_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            sgn_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            word_q  <= 32'h0;
            rdata_q <= 32'h0;
        end else if (accept) begin
            we_q    <= bus.req_we;
            sgn_q   <= bus.req_signed;
            size_q  <= bus.req_size;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            err_q   <= req_err;
            rdata_q <= 32'h0;
        end else if (state == READ) begin
            word_q <= bus.mem_out;
            if (!we_q) rdata_q <= load_val;
        end
    end

    always_comb begin
        bus.req_ready      = (state == IDLE);
        bus.resp_valid     = (state == RESP);
        bus.resp_rdata     = rdata_q;
        bus.resp_err       = err_q;
        bus.mem_read       = (state == READ);
        bus.mem_write      = (state == WRITE);
        bus.mem_address    = 32'h0;
        bus.mem_write_data = 32'h0;
        if (state == READ || state == WRITE) bus.mem_address = {addr_q[31:2], 2'b00};
        if (state == WRITE)                  bus.mem_write_data = merged;
    end
endmodule
